// File: rtl/csi_tx_packet_builder.sv
`default_nettype none
// ============================================================================
//  Module   : csi_header_ecc / csi_tx_packet_builder
//  Purpose  : CSI-2 transmit packet builder for a single virtual channel.
//             Turns FS / FE / LINE commands plus a 32-bit pixel stream into
//             framed 32-bit words: short packets (header word only) and long
//             packets (header, payload words, CRC-16 footer word). Every
//             packet is followed by a low-power gap.
//  Ports    : clock, reset_n (async, active low), enable (clock enable)
//             cmd_valid/cmd_type/cmd_ready    : command handshake
//             pix_data/pix_valid/pix_ready    : payload handshake
//             out_data/out_valid/out_ready    : packet word handshake
//             out_frame                       : header..last word of packet
//             lp_mode                         : no packet in flight
//             frame_num                       : current frame number
//  Revision : 1.0  initial release
// ============================================================================

// 24-bit CSI-2 packet header ECC (6 parity bits, top two bits zero).
module csi_header_ecc (
  input  logic [23:0] i_hdr,
  output logic [7:0]  o_ecc
);
  always_comb begin
    o_ecc    = 8'h00;
    o_ecc[0] = ^(i_hdr & 24'hF12CB7);
    o_ecc[1] = ^(i_hdr & 24'hF2555B);
    o_ecc[2] = ^(i_hdr & 24'h749A6D);
    o_ecc[3] = ^(i_hdr & 24'hB8E38E);
    o_ecc[4] = ^(i_hdr & 24'hDF03F0);
    o_ecc[5] = ^(i_hdr & 24'hEFFC00);
  end
endmodule

module csi_tx_packet_builder #(
  parameter logic [1:0]  VC            = 2'b00,
  parameter logic [5:0]  FS_DT         = 6'h00,
  parameter logic [5:0]  FE_DT         = 6'h01,
  parameter logic [5:0]  VIDEO_DT      = 6'h2A,
  parameter logic [15:0] LINE_BYTES    = 16'd2560,
  parameter logic [15:0] FRAME_NUM_MAX = 16'd0,
  parameter int          GAP_CYCLES    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_type,
  output logic        cmd_ready,
  input  logic [31:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  output logic        out_frame,
  input  logic        out_ready,
  output logic        lp_mode,
  output logic [15:0] frame_num
);

  localparam logic [2:0]  c_st_idle    = 3'd0;
  localparam logic [2:0]  c_st_hdr     = 3'd1;
  localparam logic [2:0]  c_st_pay     = 3'd2;
  localparam logic [2:0]  c_st_crc     = 3'd3;
  localparam logic [2:0]  c_st_gap     = 3'd4;

  localparam logic [1:0]  c_cmd_fs     = 2'd0;
  localparam logic [1:0]  c_cmd_fe     = 2'd1;
  localparam logic [1:0]  c_cmd_line   = 2'd2;
  localparam logic [1:0]  c_cmd_rsvd   = 2'd3;

  localparam logic [15:0] c_line_words = {2'b00, LINE_BYTES[15:2]};
  localparam logic [7:0]  c_gap_load   = 8'(GAP_CYCLES - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [31:0] r_out_data;
  logic        r_full;
  logic        r_is_line;
  logic [15:0] r_word_cnt;
  logic [15:0] r_crc;
  logic [7:0]  r_gap_cnt;
  logic [15:0] r_frame_num;
  logic        r_cmd_ready;

  logic        w_out_valid;
  logic        w_out_frame;
  logic        w_lp_mode;
  logic        w_pix_ready;
  logic        w_cmd_fire;
  logic        w_pix_fire;
  logic        w_out_fire;
  logic [15:0] w_fn_next;
  logic [15:0] w_hdr_wc;
  logic [5:0]  w_hdr_dt;
  logic [23:0] w_hdr24;
  logic [7:0]  w_ecc;

  // CRC-16 (reflected 0x8408) over one 32-bit word, byte0 first, LSB first.
  function automatic logic [15:0] f_crc16_word(input logic [15:0] crc,
                                               input logic [31:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'h8408;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Header word construction
  // --------------------------------------------------------------------------
  always_comb begin
    if (FRAME_NUM_MAX == 16'd0)            w_fn_next = 16'd0;
    else if (r_frame_num >= FRAME_NUM_MAX) w_fn_next = 16'd1;
    else                                   w_fn_next = r_frame_num + 16'd1;

    w_hdr_wc = LINE_BYTES;
    w_hdr_dt = VIDEO_DT;
    case (cmd_type)
      c_cmd_fs: begin
        // FS carries the frame number it is about to start.
        w_hdr_wc = w_fn_next;
        w_hdr_dt = FS_DT;
      end
      c_cmd_fe: begin
        w_hdr_wc = r_frame_num;
        w_hdr_dt = FE_DT;
      end
      default: begin
        w_hdr_wc = LINE_BYTES;
        w_hdr_dt = VIDEO_DT;
      end
    endcase
  end

  assign w_hdr24 = {w_hdr_wc, VC, w_hdr_dt};

  csi_header_ecc u_ecc (
    .i_hdr (w_hdr24),
    .o_ecc (w_ecc)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_state <= c_st_idle;
    else if (enable) r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_cmd_fire && (cmd_type != c_cmd_rsvd)) w_state_next = c_st_hdr;
      c_st_hdr:  if (w_out_fire) w_state_next = r_is_line ? c_st_pay : c_st_gap;
      // Leave PAY only once the last payload word has left the output register.
      c_st_pay:  if (w_out_fire && (r_word_cnt == 16'd0)) w_state_next = c_st_crc;
      c_st_crc:  if (w_out_fire) w_state_next = c_st_gap;
      c_st_gap:  if (enable && (r_gap_cnt == 8'd0)) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_out_valid = 1'b0;
    w_out_frame = 1'b0;
    w_lp_mode   = 1'b0;
    w_pix_ready = 1'b0;
    case (r_state)
      c_st_idle: w_lp_mode = 1'b1;
      c_st_hdr: begin
        w_out_valid = 1'b1;
        w_out_frame = 1'b1;
      end
      c_st_pay: begin
        w_out_valid = r_full;
        w_out_frame = 1'b1;
        // Accept a new word when the output register drains this cycle or
        // is already empty, and only while payload words are still owed.
        w_pix_ready = (r_word_cnt != 16'd0) && (out_ready || !r_full);
      end
      c_st_crc: begin
        w_out_valid = 1'b1;
        w_out_frame = 1'b1;
      end
      default: w_lp_mode = 1'b1;
    endcase
  end

  assign w_cmd_fire = enable && cmd_valid && r_cmd_ready;
  assign w_pix_fire = enable && pix_valid && w_pix_ready;
  assign w_out_fire = enable && w_out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= 32'h0;
      r_full      <= 1'b0;
      r_is_line   <= 1'b0;
      r_word_cnt  <= 16'd0;
      r_crc       <= 16'hFFFF;
      r_gap_cnt   <= 8'd0;
      r_frame_num <= 16'd0;
      r_cmd_ready <= 1'b0;
    end else if (enable) begin
      // cmd_ready is registered so it reads 0 while reset is asserted and
      // tracks the IDLE state from the first enabled clock afterwards.
      r_cmd_ready <= (w_state_next == c_st_idle);
      case (r_state)
        c_st_idle: begin
          if (w_cmd_fire && (cmd_type != c_cmd_rsvd)) begin
            r_out_data <= {w_ecc, w_hdr24};
            r_is_line  <= (cmd_type == c_cmd_line);
            if (cmd_type == c_cmd_fs) r_frame_num <= w_fn_next;
          end
        end
        c_st_hdr: begin
          if (w_out_fire) begin
            r_word_cnt <= c_line_words;
            r_crc      <= 16'hFFFF;
            r_full     <= 1'b0;
            r_gap_cnt  <= c_gap_load;
          end
        end
        c_st_pay: begin
          if (w_pix_fire) begin
            r_out_data <= pix_data;
            r_full     <= 1'b1;
            r_crc      <= f_crc16_word(r_crc, pix_data);
            r_word_cnt <= r_word_cnt - 16'd1;
          end else if (w_out_fire) begin
            r_full <= 1'b0;
            if (r_word_cnt == 16'd0) r_out_data <= {16'h0000, r_crc};
          end
        end
        c_st_crc: begin
          if (w_out_fire) r_gap_cnt <= c_gap_load;
        end
        c_st_gap: begin
          if (r_gap_cnt != 8'd0) r_gap_cnt <= r_gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign pix_ready = w_pix_ready;
  assign out_data  = r_out_data;
  assign out_valid = w_out_valid;
  assign out_frame = w_out_frame;
  assign lp_mode   = w_lp_mode;
  assign frame_num = r_frame_num;

endmodule
`default_nettype wire

// File: tb/tb_csi_tx_packet_builder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csi_tx_packet_builder
//  Purpose  : Self-checking bench for csi_tx_packet_builder with a packet-
//             level reference model (header ECC table, bytewise CRC table).
//  Revision : 1.0  initial release
// ============================================================================
module tb_csi_tx_packet_builder;

  localparam int          LB   = 8;
  localparam int          NW   = LB / 4;
  localparam logic [15:0] FMAX = 16'd3;
  localparam int          GAP  = 4;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        enable    = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type  = 2'd0;
  logic        cmd_ready;
  logic [31:0] pix_data  = 32'h0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_frame;
  logic        out_ready = 1'b0;
  logic        lp_mode;
  logic [15:0] frame_num;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] crc_tab [256];
  logic [5:0]  ecc_col [24];
  logic [31:0] pix_q [$];
  logic [15:0] fn_model = 16'd0;

  always #5 clock = ~clock;

  csi_tx_packet_builder #(
    .LINE_BYTES    (16'(LB)),
    .FRAME_NUM_MAX (FMAX),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_ready (cmd_ready),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_frame (out_frame),
    .out_ready (out_ready),
    .lp_mode   (lp_mode),
    .frame_num (frame_num)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ECC = XOR of the syndrome columns of every set header bit.
  function automatic logic [7:0] ecc_of(input logic [23:0] h);
    logic [5:0] p;
    p = 6'h00;
    for (int i = 0; i < 24; i++) if (h[i]) p = p ^ ecc_col[i];
    return {2'b00, p};
  endfunction

  function automatic logic [31:0] hdr_word(input logic [15:0] wc, input logic [5:0] dt);
    logic [23:0] h;
    h = {wc, 2'b00, dt};
    return {ecc_of(h), h};
  endfunction

  function automatic logic [15:0] crc_of(input logic [31:0] w [$]);
    logic [15:0] c;
    logic [7:0]  by;
    c = 16'hFFFF;
    foreach (w[k]) begin
      for (int b = 0; b < 4; b++) begin
        by = w[k][8*b +: 8];
        c  = (c >> 8) ^ crc_tab[c[7:0] ^ by];
      end
    end
    return c;
  endfunction

  task automatic fill_pix();
    pix_q.delete();
    for (int k = 0; k < NW; k++) pix_q.push_back($urandom);
  endtask

  // Issues one command and follows it through its packet and gap.
  // rmode: 0 out_ready=1, 1 random, 2 five-cycle stall on first payload word
  // vmode: 0 pix_valid=1, 1 random, 2 three-cycle drop after first word
  task automatic run_cmd(input logic [1:0] typ, input int rmode, input int vmode);
    logic [31:0] exp_q [$];
    int nout = 0, pi = 0, cyc = 0, stall_left = 5, vdrop = 0;
    int gap_len = 0, bad = 0, quiet = 0;
    bit taken = 0, stalling = 0, dropping = 0, in_gap = 0, finished = 0;
    case (typ)
      2'd0: begin
        fn_model = (FMAX == 16'd0) ? 16'd0 : (fn_model == FMAX) ? 16'd1 : fn_model + 16'd1;
        exp_q.push_back(hdr_word(fn_model, 6'h00));
      end
      2'd1: exp_q.push_back(hdr_word(fn_model, 6'h01));
      2'd2: begin
        exp_q.push_back(hdr_word(16'(LB), 6'h2A));
        foreach (pix_q[k]) exp_q.push_back(pix_q[k]);
        exp_q.push_back({16'h0000, crc_of(pix_q)});
      end
      default: ;
    endcase
    while (cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
      // drive
      cmd_valid = in_gap ? 1'b1 : !taken;
      cmd_type  = in_gap ? 2'd3 : typ;
      out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rmode == 2 && !stalling && stall_left == 5 && nout == 1 && out_valid) stalling = 1;
      if (stalling) out_ready = 1'b0;
      pix_valid = 1'b0;
      dropping  = 0;
      if (typ == 2'd2 && taken && pi < NW) begin
        pix_valid = (vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (vmode == 2 && pi == 1 && vdrop < 3) begin
          pix_valid = 1'b0;
          dropping  = 1;
          vdrop++;
        end
        pix_data = pix_q[pi];
      end
      #1;
      // sample
      if (stalling) begin
        check("stall_out_data", out_data, pix_q[0]);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_pix_ready", 32'(pix_ready), 32'd0);
        stall_left--;
        if (stall_left == 0) stalling = 0;
      end
      if (dropping && vdrop >= 2) begin
        check("drop_out_valid", 32'(out_valid), 32'd0);
        check("drop_out_frame", 32'(out_frame), 32'd1);
      end
      if (in_gap) begin
        if (cmd_ready) begin
          check("gap_cycles", 32'(gap_len), 32'(GAP));
          check("gap_bad", 32'(bad), 32'd0);
          finished = 1;
          break;
        end
        gap_len++;
        if (lp_mode !== 1'b1 || out_frame !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      if (typ == 2'd3 && taken) begin
        quiet++;
        if (out_valid !== 1'b0 || lp_mode !== 1'b1) bad++;
        if (quiet == 6) begin
          check("rsvd_quiet", 32'(bad), 32'd0);
          check("rsvd_cmd_ready", 32'(cmd_ready), 32'd1);
          finished = 1;
          break;
        end
      end
      if (!taken && cmd_valid && cmd_ready) taken = 1;
      if (pix_valid && pix_ready) pi++;
      if (out_valid && out_ready && !in_gap) begin
        if (nout < exp_q.size()) begin
          check("word", out_data, exp_q[nout]);
          check("word_frame_lp", {30'd0, out_frame, lp_mode}, 32'd2);
        end
        nout++;
        if (nout == exp_q.size()) in_gap = 1;
      end
    end
    if (!finished) check("timeout", 32'd0, 32'd1);
    check("word_count", 32'(nout), 32'(exp_q.size()));
    check("frame_num", 32'(frame_num), 32'(fn_model));
    cmd_valid = 1'b0;
    pix_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] c;
    bit          got;
    ecc_col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    for (int n = 0; n < 256; n++) begin
      c = 16'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tab[n] = c;
    end

    // reset state
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_frame", 32'(out_frame), 32'd0);
    check("rst_lp_mode", 32'(lp_mode), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_frame_num", 32'(frame_num), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // frame starts wrap 1,2,3,1; then a frame end
    repeat (4) run_cmd(2'd0, 1, 0);
    run_cmd(2'd1, 0, 0);

    // fixed payload 00..07
    pix_q.delete();
    pix_q.push_back(32'h03020100);
    pix_q.push_back(32'h07060504);
    run_cmd(2'd2, 0, 0);

    // output back-pressure mid payload
    fill_pix();
    run_cmd(2'd2, 2, 0);

    // pixel starvation mid line
    fill_pix();
    run_cmd(2'd2, 0, 2);

    // random handshakes
    repeat (4) begin
      fill_pix();
      run_cmd(2'd2, 1, 1);
    end

    // reserved command
    run_cmd(2'd3, 0, 0);

    // reset in the middle of the payload
    fill_pix();
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_type  = 2'd2;
    out_ready = 1'b1;
    pix_valid = 1'b1;
    pix_data  = pix_q[0];
    got = 0;
    for (int g = 0; g < 20 && !got; g++) begin
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      if (out_valid && out_frame && out_data === pix_q[0]) got = 1;
    end
    check("reach_pay", 32'(got), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_frame", 32'(out_frame), 32'd0);
    check("arst_lp_mode", 32'(lp_mode), 32'd1);
    check("arst_pix_ready", 32'(pix_ready), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_frame_num", 32'(frame_num), 32'd0);
    fn_model  = 16'd0;
    pix_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    fill_pix();
    run_cmd(2'd2, 1, 0);
    run_cmd(2'd0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
